// File: rtl/if_fetch_predict_pkg.sv
// Shared constants and types for the instruction-fetch stage and its branch predictor.
package if_fetch_predict_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        CNT_STRONG_NT = 2'b00,
        CNT_WEAK_NT   = 2'b01,
        CNT_WEAK_T    = 2'b10,
        CNT_STRONG_T  = 2'b11
    } cnt_e;

    localparam cnt_e CNT_RESET = CNT_WEAK_NT;

    // Saturating 2-bit direction counter step.
    function automatic cnt_e cnt_train(input cnt_e c, input logic taken);
        if (taken) begin
            return (c == CNT_STRONG_T) ? CNT_STRONG_T : cnt_e'(c + 2'd1);
        end
        return (c == CNT_STRONG_NT) ? CNT_STRONG_NT : cnt_e'(c - 2'd1);
    endfunction

endpackage

// File: rtl/if_fetch_predict_bht_btb.sv
// Direct-mapped branch target buffer with 2-bit counters: one lookup port, one training port.
module if_fetch_predict_bht_btb
    import if_fetch_predict_pkg::*;
#(
    parameter int ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lkp_pc_i,
    output logic        lkp_hit_o,
    output logic [31:0] lkp_target_o,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_taken_i,
    input  logic [31:0] upd_target_i
);

    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = 30 - IDX;

    cnt_e             cnt_q [ENTRIES];
    logic [ENTRIES-1:0] valid_q;
    logic [TAGW-1:0]  tag_q [ENTRIES];
    logic [31:0]      tgt_q [ENTRIES];

    logic [IDX-1:0]   lkp_idx, upd_idx;
    logic [TAGW-1:0]  lkp_tag, upd_tag;
    logic             unused_bits;

    assign lkp_idx = lkp_pc_i[IDX+1:2];
    assign lkp_tag = lkp_pc_i[31:IDX+2];
    assign upd_idx = upd_pc_i[IDX+1:2];
    assign upd_tag = upd_pc_i[31:IDX+2];
    assign unused_bits = ^{lkp_pc_i[1:0], upd_pc_i[1:0]};

    assign lkp_hit_o    = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag)
                          && (cnt_q[lkp_idx] >= CNT_WEAK_T);
    assign lkp_target_o = tgt_q[lkp_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < ENTRIES; e++) begin
                cnt_q[e] <= CNT_RESET;
            end
            valid_q <= '0;
        end else if (upd_valid_i) begin
            cnt_q[upd_idx] <= cnt_train(cnt_q[upd_idx], upd_taken_i);
            if (upd_taken_i) begin
                valid_q[upd_idx] <= 1'b1;
            end
        end
    end

    // Tag and target are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (!rst && upd_valid_i && upd_taken_i) begin
            tag_q[upd_idx] <= upd_tag;
            tgt_q[upd_idx] <= upd_target_i;
        end
    end

endmodule

// File: rtl/if_fetch_predict.sv
// Fetch stage: PC register, next-PC priority mux and bubble insertion into IF/ID.
// IF_BRANCH_PREDICT_EN builds the BHT/BTB; otherwise fetch is always sequential.
module if_fetch_predict
    import if_fetch_predict_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          BHT_ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_next_pc,
    output logic [31:0] if_inst,
    output logic        if_predicted_bit
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] seq_pc, pred_pc;
    logic        pred_hit;
    logic        bubble;

    assign seq_pc = pc_q + 32'd4;

`ifdef IF_BRANCH_PREDICT_EN
    logic [31:0] btb_target;

    if_fetch_predict_bht_btb #(
        .ENTRIES(BHT_ENTRIES)
    ) u_bht_btb (
        .clk          (clk),
        .rst          (rst),
        .lkp_pc_i     (pc_q),
        .lkp_hit_o    (pred_hit),
        .lkp_target_o (btb_target),
        .upd_valid_i  (upd_valid),
        .upd_pc_i     (upd_pc),
        .upd_taken_i  (upd_taken),
        .upd_target_i (upd_target)
    );

    assign pred_pc = pred_hit ? btb_target : seq_pc;
`else
    localparam int unused_entries = BHT_ENTRIES;
    logic unused_upd;

    assign unused_upd = ^{upd_valid, upd_pc, upd_taken, upd_target};
    assign pred_hit   = 1'b0;
    assign pred_pc    = seq_pc;
`endif

    assign bubble = !imem_ready || redirect_valid;

    assign imem_addr        = pc_q;
    assign if_pc            = pc_q;
    assign if_next_pc       = bubble ? pc_q : pred_pc;
    assign if_inst          = bubble ? NOP_INST : imem_rdata;
    assign if_predicted_bit = !bubble && pred_hit;

    // Redirect overrides stall; a miss holds the PC just like a stall.
    always_comb begin
        pc_d = pred_pc;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (stall || !imem_ready) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule
